ucode_sequencer_stk: RTL

Parametrised next-generation microcode sequencer for the Sol-1 core, with a micro-subroutine stack, a hardware loop counter, a stall input and a registered control-word pipeline. It generates the microcode ROM address each cycle from the current word's sequencing fields, the IR, the selected condition and the interrupt request. It presents the ROM word, delayed by half a cycle, to the datapath.

---
 rtl/ucode_sequencer_stk.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ucode_sequencer_stk.sv
// ucode_sequencer_stk: microcode sequencer with call stack, loop counter,
// stall and a half-cycle registered control word.
// Optional build macro: UCODE_STACK_GUARD_EN. When it is defined, stack
// overflow and underflow raise a sticky fault and trap to FAULT_UADDR.
// When it is undefined, the stack drops its oldest entry on overflow and
// RET on underflow returns to FETCH_UADDR.
module ucode_sequencer_stk #(
  parameter int unsigned UADDR_W     = 14,
  parameter int unsigned CW_W        = 120,
  parameter int unsigned OFFSET_W    = 7,
  parameter int unsigned NCOND       = 16,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned FETCH_UADDR = 'h10,
  parameter int unsigned TRAP_UADDR  = 'h20
`ifdef UCODE_STACK_GUARD_EN
  ,
  parameter int unsigned FAULT_UADDR = 'h30
`endif
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic [7:0]                   ir,
  input  logic [CW_W-1:0]              rom_data,
  input  logic [2:0]                   seq_typ,
  input  logic [OFFSET_W-1:0]          seq_offset,
  input  logic [$clog2(NCOND)-1:0]     seq_cond_sel,
  input  logic                         seq_cond_invert,
  input  logic                         seq_escape,
  input  logic [NCOND-1:0]             cond_vec,
  input  logic                         any_interruption,
  input  logic                         stall,
  input  logic                         fault_clr,
  output logic [UADDR_W-1:0]           uaddr,
  output logic [CW_W-1:0]              cw_q,
  output logic [$clog2(DEPTH+1)-1:0]   stk_depth,
  output logic [OFFSET_W-1:0]          loop_cnt,
  output logic                         fault
);

  localparam int unsigned DEPTH_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

  typedef enum logic [2:0] {
    TYP_JMP   = 3'b000,
    TYP_BR    = 3'b001,
    TYP_END   = 3'b010,
    TYP_DEC   = 3'b011,
    TYP_CALL  = 3'b100,
    TYP_RET   = 3'b101,
    TYP_LOOP  = 3'b110,
    TYP_LDCNT = 3'b111
  } seq_typ_e;

  logic [UADDR_W-1:0]  stk_mem [DEPTH];
  logic [UADDR_W-1:0]  uaddr_nxt;
  logic [UADDR_W-1:0]  uaddr_inc;
  logic [UADDR_W-1:0]  uaddr_tgt;
  logic [UADDR_W-1:0]  ret_addr;
  logic [DEPTH_W-1:0]  depth_nxt;
  logic [OFFSET_W-1:0] loop_nxt;
  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    pop_idx;
  logic                cond;
  logic                stk_full;
  logic                stk_empty;
  logic                push;
  logic                shift;
  logic                fault_set;

  assign cond      = cond_vec[seq_cond_sel] ^ seq_cond_invert;
  assign uaddr_inc = uaddr + UADDR_W'(1);
  assign uaddr_tgt = uaddr + UADDR_W'(seq_offset);
  assign stk_full  = (stk_depth == DEPTH_MAX);
  assign stk_empty = (stk_depth == '0);
  assign push_idx  = IDX_W'(stk_depth);
  assign pop_idx   = IDX_W'(stk_depth - DEPTH_W'(1));
  assign ret_addr  = stk_mem[pop_idx];

  // Next micro-address, stack, loop and fault decisions from the current word
  always_comb begin
    uaddr_nxt = uaddr;
    depth_nxt = stk_depth;
    loop_nxt  = loop_cnt;
    push      = 1'b0;
    shift     = 1'b0;
    fault_set = 1'b0;
    if (!stall) begin
      case (seq_typ_e'(seq_typ))
        TYP_JMP: uaddr_nxt = uaddr_tgt;
        TYP_BR:  uaddr_nxt = cond ? uaddr_tgt : uaddr_inc;
        TYP_END: begin
          uaddr_nxt = any_interruption ? UADDR_W'(TRAP_UADDR) : UADDR_W'(FETCH_UADDR);
          depth_nxt = '0;
        end
        TYP_DEC: uaddr_nxt = (UADDR_W'(ir) << (UADDR_W - 8)) |
                             (UADDR_W'(seq_escape) << (UADDR_W - 10));
        TYP_CALL: begin
`ifdef UCODE_STACK_GUARD_EN
          if (stk_full) begin
            fault_set = 1'b1;
            uaddr_nxt = UADDR_W'(FAULT_UADDR);
          end else begin
            push      = 1'b1;
            depth_nxt = stk_depth + DEPTH_W'(1);
            uaddr_nxt = uaddr_tgt;
          end
`else
          push      = 1'b1;
          shift     = stk_full;
          uaddr_nxt = uaddr_tgt;
          if (!stk_full) depth_nxt = stk_depth + DEPTH_W'(1);
`endif
        end
        TYP_RET: begin
          if (stk_empty) begin
`ifdef UCODE_STACK_GUARD_EN
            fault_set = 1'b1;
            uaddr_nxt = UADDR_W'(FAULT_UADDR);
`else
            uaddr_nxt = UADDR_W'(FETCH_UADDR);
`endif
          end else begin
            depth_nxt = stk_depth - DEPTH_W'(1);
            uaddr_nxt = ret_addr;
          end
        end
        TYP_LOOP: begin
          if (loop_cnt != '0) begin
            loop_nxt  = loop_cnt - OFFSET_W'(1);
            uaddr_nxt = uaddr_tgt;
          end else begin
            uaddr_nxt = uaddr_inc;
          end
        end
        TYP_LDCNT: begin
          loop_nxt  = seq_offset;
          uaddr_nxt = uaddr_inc;
        end
        default: uaddr_nxt = uaddr;
      endcase
    end
  end

  // Sequencer state registers; fault set has priority over clear
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      uaddr     <= '0;
      stk_depth <= '0;
      loop_cnt  <= '0;
      fault     <= 1'b0;
    end else begin
      uaddr     <= uaddr_nxt;
      stk_depth <= depth_nxt;
      loop_cnt  <= loop_nxt;
      fault     <= fault_set | (fault & ~(fault_clr & ~stall));
    end
  end

  // Return-address storage; not reset, occupancy tracks validity
  always_ff @(posedge clk) begin
    if (push) begin
      if (shift) begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          stk_mem[i] <= stk_mem[i+1];
        end
        stk_mem[DEPTH-1] <= uaddr_inc;
      end else begin
        stk_mem[push_idx] <= uaddr_inc;
      end
    end
  end

  // Control word captured mid-cycle so it is stable across the next posedge
  always_ff @(negedge clk or negedge arst_n) begin
    if (!arst_n) cw_q <= '0;
    else         cw_q <= rom_data;
  end

endmodule
